// File: rtl/isp_line_buffer.sv
// Multi-line pixel buffer: stores LINES-1 lines in SDP RAM banks and emits a LINES-tall column
// per pixel. Define ISP_LINEBUF_EDGE_REPLICATE_EN for top-edge replication instead of warm-up.
module isp_line_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LINE_DEPTH = 4096,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LINES      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_sof,
    input  logic                          in_last,
    output logic                          out_valid,
    output logic [LINES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_sof,
    output logic                          out_last,
    output logic                          overflow
);

    localparam int unsigned NB   = LINES - 1;
    localparam int unsigned WP_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned RW   = $clog2(LINES);

    localparam logic [WP_W-1:0]       WP_MAX   = WP_W'(NB - 1);
    localparam logic [RW-1:0]         ROWS_MAX = RW'(NB);
    localparam logic [ADDR_WIDTH-1:0] COL_MAX  = ADDR_WIDTH'(LINE_DEPTH - 1);

    logic                  sof_v, last_v, accept, ovf_hit;
    logic [ADDR_WIDTH-1:0] col, col_eff, col_d;
    logic [WP_W-1:0]       wp, wp_eff, wp_d;
    logic [RW-1:0]         rows, rows_eff, rows_d;
    logic                  drop, drop_eff, drop_d, overflow_d;

    // Start-of-frame forces the line state to zero before the pixel is processed.
    always_comb begin
        sof_v      = in_valid & in_sof;
        last_v     = in_valid & in_last;
        col_eff    = sof_v ? '0 : col;
        wp_eff     = sof_v ? '0 : wp;
        rows_eff   = sof_v ? '0 : rows;
        drop_eff   = sof_v ? 1'b0 : drop;
        accept     = in_valid & ~drop_eff;
        ovf_hit    = accept & ~in_last & (col_eff == COL_MAX);

        col_d      = col_eff;
        wp_d       = wp_eff;
        rows_d     = rows_eff;
        drop_d     = drop_eff;
        overflow_d = sof_v ? 1'b0 : overflow;

        if (accept) col_d = col_eff + 1'b1;
        if (ovf_hit) begin
            drop_d     = 1'b1;
            overflow_d = 1'b1;
        end
        if (last_v) begin
            col_d  = '0;
            drop_d = 1'b0;
            wp_d   = (wp_eff == WP_MAX) ? '0 : wp_eff + 1'b1;
            rows_d = (rows_eff == ROWS_MAX) ? rows_eff : rows_eff + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            wp       <= '0;
            rows     <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            col      <= col_d;
            wp       <= wp_d;
            rows     <= rows_d;
            drop     <= drop_d;
            overflow <= overflow_d;
        end
    end

    // Stage 1: slice-0 pixel and sideband travel alongside the RAM read register.
    logic                  v1, sof1, last1;
    logic [DATA_WIDTH-1:0] pix1;
    logic [WP_W-1:0]       wp1;
    logic [RW-1:0]         rows1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sof1  <= 1'b0;
            last1 <= 1'b0;
            pix1  <= '0;
            wp1   <= '0;
            rows1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                sof1  <= in_sof;
                last1 <= in_last;
                pix1  <= in_data;
                wp1   <= wp_eff;
                rows1 <= rows_eff;
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_data [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [LINE_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // Read-first: the read in the write cycle returns the line being replaced.
        always_ff @(posedge clk) begin
            if (accept) begin
                if (wp_eff == WP_W'(b)) mem[col_eff] <= in_data;
                rd_q <= mem[col_eff];
            end
        end

        assign rd_data[b] = rd_q;
    end

    function automatic logic [WP_W-1:0] bank_of(input logic [WP_W-1:0] w, input int unsigned k);
        int unsigned s;
        s = 32'(w) + NB - k;
        if (s >= NB) s = s - NB;
        return WP_W'(s);
    endfunction

    logic [DATA_WIDTH-1:0]       tap [LINES];
    logic [DATA_WIDTH-1:0]       sel [LINES];
    logic [LINES*DATA_WIDTH-1:0] col_flat;
    logic                        emit;

    always_comb begin
        tap[0] = pix1;
        for (int unsigned k = 1; k < LINES; k++) tap[k] = rd_data[bank_of(wp1, k)];
        for (int unsigned k = 0; k < LINES; k++) begin
`ifdef ISP_LINEBUF_EDGE_REPLICATE_EN
            // Taps above the first frame row repeat the oldest valid row.
            sel[k] = (k > 32'(rows1)) ? tap[rows1] : tap[k];
`else
            sel[k] = tap[k];
`endif
            col_flat[k*DATA_WIDTH +: DATA_WIDTH] = sel[k];
        end
`ifdef ISP_LINEBUF_EDGE_REPLICATE_EN
        emit = v1;
`else
        emit = v1 & (rows1 == ROWS_MAX);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_data <= col_flat;
                out_sof  <= sof1;
                out_last <= last1;
            end
        end
    end

endmodule
